// File: rtl/ls148_key_encoder.sv
// ls148_key_encoder
//   Debounced, clocked version of a 74LS148 8-to-3 priority encoder.
//   The block synchronises the request lines and waits for a stable
//   pattern. It then issues a single code/multi result over a
//   valid/ready handshake. No further result is issued until every line
//   has been released.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   en_n       active-low enable (EI)
//   i_n[7:0]   active-low request lines, asynchronous to clk
//   ready      consumer accepts the code while valid is high
//   code[2:0]  index of the highest requested line in the captured pattern
//   valid      code/multi hold a debounced result
//   multi      more than one line was low in the captured pattern
//   gs_n       active-low group select (enabled, some line requested)
//   eo_n       active-low enable out (enabled, no line requested)
//   dbg_state  current FSM state: 0 IDLE, 1 DEBOUNCE, 2 HOLD, 3 RELEASE
//
// Handshake: a transfer happens at any rising edge where valid and ready
// are both high. Once valid is raised, valid, code and multi stay constant
// until that transfer. The consumer may hold ready high all the time, so
// the minimum valid width is one cycle. code and multi keep their last
// values after valid falls.
module ls148_key_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_n,
    input  logic [7:0] i_n,
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic       multi,
    output logic       gs_n,
    output logic       eo_n,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Last counter value before the result is issued.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    state_t     state;
    logic [7:0] sync1;
    logic [7:0] sync;
    logic [7:0] snap;
    logic [7:0] cnt;

    logic [2:0] snap_code;
    logic       snap_multi;
    logic [7:0] snap_req;

    // Two-stage synchroniser for the asynchronous request lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 8'hFF;
            sync  <= 8'hFF;
        end else begin
            sync1 <= i_n;
            sync  <= sync1;
        end
    end

    // Highest-numbered low bit wins. The loop runs upward, so later
    // (higher) matches overwrite earlier ones.
    always_comb begin
        snap_code = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!snap[k]) snap_code = 3'(k);
        end
    end

    // Clearing the lowest set bit leaves a nonzero value only when at
    // least two lines are requested.
    assign snap_req   = ~snap;
    assign snap_multi = (snap_req & (snap_req - 8'd1)) != 8'd0;

    // Group-select / enable-out flags track the synchronised lines every
    // cycle, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gs_n <= 1'b1;
            eo_n <= 1'b1;
        end else begin
            gs_n <= en_n | (sync == 8'hFF);
            eo_n <= en_n | (sync != 8'hFF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            snap  <= 8'hFF;
            cnt   <= 8'd0;
            code  <= 3'b000;
            multi <= 1'b0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!en_n && sync != 8'hFF) begin
                        snap  <= sync;
                        cnt   <= 8'd0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (en_n || sync != snap) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        code  <= snap_code;
                        multi <= snap_multi;
                        valid <= 1'b1;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    // Input changes are ignored here; only the consumer
                    // can end the hold.
                    if (ready) begin
                        valid <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // A line that stays held must not be reported twice.
                    if (sync == 8'hFF) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_ls148_key_encoder.sv
module tb_ls148_key_encoder;

    localparam int DB = 4;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic       clk;
    logic       rst_n;
    logic       en_n;
    logic [7:0] i_n;
    logic       ready;
    logic [2:0] code;
    logic       valid;
    logic       multi;
    logic       gs_n;
    logic       eo_n;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    // Scoreboard entries are {multi, code}.
    logic [3:0] exp_q[$];
    logic       prev_valid = 1'b0;

    ls148_key_encoder #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_n      (en_n),
        .i_n       (i_n),
        .ready     (ready),
        .code      (code),
        .valid     (valid),
        .multi     (multi),
        .gs_n      (gs_n),
        .eo_n      (eo_n),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    // Every rising edge of valid must match the oldest expected result.
    always @(negedge clk) begin
        logic [3:0] e;
        if (valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("mon_code", {29'd0, code}, {29'd0, e[2:0]});
                check("mon_multi", {31'd0, multi}, {31'd0, e[3]});
            end
        end
        prev_valid = valid;
    end

    // ---------------- driver tasks ----------------
    // Applies a pattern and waits for valid. Returns the edge count at which
    // valid was first seen, where edge 1 samples the new pattern.
    task automatic apply_and_wait(input logic [7:0] pat, input logic [2:0] exp_code,
                                  input logic exp_multi, output int lat);
        exp_q.push_back({exp_multi, exp_code});
        @(posedge clk); #1;
        i_n = pat;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            check("valid_timeout", 32'd0, 32'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_back());
        end
    endtask

    task automatic handshake();
        @(posedge clk); #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        check("valid_after_ready", {31'd0, valid}, 32'd0);
        check("state_release", {30'd0, dbg_state}, {30'd0, ST_RELEASE});
    endtask

    task automatic release_lines();
        @(posedge clk); #1;
        i_n = 8'hFF;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("state_idle_after_release", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    endtask

    // Full press: debounce, hold with ready low, handshake, release.
    task automatic press(input logic [7:0] pat, input logic [2:0] exp_code,
                         input logic exp_multi, input int hold_cycles);
        int  lat;
        bit  stable;
        apply_and_wait(pat, exp_code, exp_multi, lat);
        check("latency", lat, DB + 3);
        check("gs_n_held", {31'd0, gs_n}, 32'd0);
        stable = 1'b1;
        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clk);
            if (!valid || code !== exp_code || multi !== exp_multi) stable = 1'b0;
        end
        check("hold_stable", {31'd0, stable}, 32'd1);
        handshake();
        check("code_kept", {29'd0, code}, {29'd0, exp_code});
        release_lines();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        rst_n = 1'b0;
        en_n  = 1'b0;
        i_n   = 8'hFF;
        ready = 1'b0;

        repeat (3) @(posedge clk); #1;
        check("rst_code", {29'd0, code}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_multi", {31'd0, multi}, 32'd0);
        check("rst_gs_n", {31'd0, gs_n}, 32'd1);
        check("rst_eo_n", {31'd0, eo_n}, 32'd1);

        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("eo_n_idle", {31'd0, eo_n}, 32'd0);
        check("gs_n_idle", {31'd0, gs_n}, 32'd1);

        en_n = 1'b1;
        @(posedge clk); #1;
        check("eo_n_disabled", {31'd0, eo_n}, 32'd1);
        check("gs_n_disabled", {31'd0, gs_n}, 32'd1);
        en_n = 1'b0;

        // Single line 5, held 20 cycles.
        press(8'b11011111, 3'b101, 1'b0, 20);

        // Priority.
        press(8'b01111110, 3'b111, 1'b1, 2);
        press(8'b11111010, 3'b010, 1'b1, 2);

        // Glitch shorter than the debounce window.
        @(posedge clk); #1;
        i_n = 8'b11111011;
        repeat (2) @(posedge clk); #1;
        i_n = 8'hFF;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("glitch_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("glitch_valid", {31'd0, valid}, 32'd0);

        // Line 3: handshake, keep holding (no second valid), release, press again.
        apply_and_wait(8'b11110111, 3'b011, 1'b0, lat);
        check("l3_latency", lat, DB + 3);
        handshake();
        repeat (12) @(negedge clk);
        check("l3_held_no_valid", {31'd0, valid}, 32'd0);
        check("l3_held_state", {30'd0, dbg_state}, {30'd0, ST_RELEASE});
        release_lines();
        press(8'b11110111, 3'b011, 1'b0, 1);

        // Round trip over every one-hot line.
        for (int k = 0; k < 8; k++) begin
            logic [7:0] one;
            one = 8'd1 << k;
            press(~one, 3'(k), 1'b0, 1);
        end

        // Reset during HOLD drops valid immediately.
        apply_and_wait(8'b10111111, 3'b110, 1'b0, lat);
        check("hold_state", {30'd0, dbg_state}, {30'd0, ST_HOLD});
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_hold_valid", {31'd0, valid}, 32'd0);
        check("rst_hold_code", {29'd0, code}, 32'd0);
        check("rst_hold_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        i_n = 8'hFF;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("post_rst_valid", {31'd0, valid}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
